mem_access_unit: RTL and testbench

- Memory-stage block directly downstream of the execute-stage ALU.
- Consumes the ALU result as a pass-through value or as an effective address. Performs byte/half/word loads and stores over a single-outstanding request/grant memory port.
- Aligns and extends load data, flags misaligned accesses, and hands the result to write-back over a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory stage that follows the execute-stage ALU. It passes the ALU result
// through, or uses it as an effective address for byte/half/word loads and
// stores. Memory is reached over a single-outstanding request/grant port.
// Load data is aligned and extended, misaligned accesses raise an exception,
// and the result goes to write-back over a valid/ready handshake.
//
// Ports:
//   clk, resetn                        clock (rising edge), async active-low reset
//   in_valid/in_ready                  operation handshake from execute
//   in_alu_result, in_store_data       ALU result / effective address, store data
//   in_mem_op, in_rd                   operation code, destination register
//   mem_req/mem_gnt                    memory request handshake
//   mem_wr, mem_wstrb, mem_addr        store flag, byte strobes, word address
//   mem_wdata                          lane-replicated store data
//   mem_rvalid, mem_rdata              load response
//   out_valid/out_ready                result handshake to write-back
//   out_data, out_rd                   result value, destination register
//   out_exc, out_badaddr               misaligned exception, faulting address
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [3:0]        in_mem_op,
    input  logic [RD_W-1:0]   in_rd,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_exc,
    output logic [ADDR_W-1:0] out_badaddr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [RD_W-1:0]   out_rd_q, out_rd_d;
    logic              out_exc_q, out_exc_d;
    logic [ADDR_W-1:0] out_badaddr_q, out_badaddr_d;

    // Incoming operation decode. Codes 0001..0111 fall through as "none".
    logic is_load, is_store, is_half, is_word, misaligned, accept;
    assign is_load    = in_mem_op[3] && (in_mem_op[2:0] <= 3'd4);
    assign is_store   = in_mem_op[3] && (in_mem_op[2:0] >= 3'd5);
    assign is_half    = (in_mem_op == 4'b1010) || (in_mem_op == 4'b1011) ||
                        (in_mem_op == 4'b1110);
    assign is_word    = (in_mem_op == 4'b1100) || (in_mem_op == 4'b1111);
    assign misaligned = (is_half && in_alu_result[0]) ||
                        (is_word && (in_alu_result[1:0] != 2'b00));

    // in_ready is gated by resetn so every output reads 0 while in reset.
    assign in_ready = resetn &&
                      ((state_q == S_IDLE) || ((state_q == S_RESP) && out_ready));
    assign accept   = in_valid && in_ready;

    // Store lane formatting
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_data;
    always_comb begin
        st_strb = 4'b1111;
        st_data = in_store_data;
        case (in_mem_op)
            4'b1101: begin
                st_strb = 4'b0001 << in_alu_result[1:0];
                st_data = {4{in_store_data[7:0]}};
            end
            4'b1110: begin
                st_strb = in_alu_result[1] ? 4'b1100 : 4'b0011;
                st_data = {2{in_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension from the latched op and offset
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            4'b1000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            4'b1001: ld_ext = {24'd0, ld_byte};
            4'b1010: ld_ext = {{16{ld_half[15]}}, ld_half};
            4'b1011: ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        off_d         = off_q;
        rd_d          = rd_q;
        mem_wr_d      = mem_wr_q;
        mem_wstrb_d   = mem_wstrb_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        out_data_d    = out_data_q;
        out_rd_d      = out_rd_q;
        out_exc_d     = out_exc_q;
        out_badaddr_d = out_badaddr_q;

        case (state_q)
            S_REQ: begin
                if (mem_gnt) begin
                    if (mem_wr_q) begin
                        // Stores return nothing to write back
                        state_d       = S_RESP;
                        out_data_d    = '0;
                        out_rd_d      = '0;
                        out_exc_d     = 1'b0;
                        out_badaddr_d = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d       = S_RESP;
                    out_data_d    = ld_ext;
                    out_rd_d      = rd_q;
                    out_exc_d     = 1'b0;
                    out_badaddr_d = '0;
                end
            end
            S_RESP: begin
                // Result consumed: clear it; a same-cycle accept overrides below
                if (out_ready) begin
                    state_d       = S_IDLE;
                    out_data_d    = '0;
                    out_rd_d      = '0;
                    out_exc_d     = 1'b0;
                    out_badaddr_d = '0;
                end
            end
            default: ;
        endcase

        // Accept is only possible from IDLE or a draining RESP, so launching
        // here gives back-to-back operation without a bubble.
        if (accept) begin
            if (!is_load && !is_store) begin
                state_d       = S_RESP;
                out_data_d    = in_alu_result;
                out_rd_d      = in_rd;
                out_exc_d     = 1'b0;
                out_badaddr_d = '0;
            end else if (misaligned) begin
                state_d       = S_RESP;
                out_data_d    = '0;
                out_rd_d      = '0;
                out_exc_d     = 1'b1;
                out_badaddr_d = in_alu_result;
            end else begin
                state_d     = S_REQ;
                op_d        = in_mem_op;
                off_d       = in_alu_result[1:0];
                rd_d        = in_rd;
                mem_wr_d    = is_store;
                mem_wstrb_d = is_store ? st_strb : 4'b0000;
                mem_addr_d  = {in_alu_result[ADDR_W-1:2], 2'b00};
                mem_wdata_d = is_store ? st_data : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            mem_wr_q      <= 1'b0;
            mem_wstrb_q   <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            out_data_q    <= '0;
            out_rd_q      <= '0;
            out_exc_q     <= 1'b0;
            out_badaddr_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            off_q         <= off_d;
            rd_q          <= rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_wstrb_q   <= mem_wstrb_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            out_data_q    <= out_data_d;
            out_rd_q      <= out_rd_d;
            out_exc_q     <= out_exc_d;
            out_badaddr_q <= out_badaddr_d;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_wr      = mem_wr_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign out_valid   = (state_q == S_RESP);
    assign out_data    = out_data_q;
    assign out_rd      = out_rd_q;
    assign out_exc     = out_exc_q;
    assign out_badaddr = out_badaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [3:0]  in_mem_op;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_exc;
    logic [31:0] out_badaddr;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_mem_op    (in_mem_op),
        .in_rd        (in_rd),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_exc      (out_exc),
        .out_badaddr  (out_badaddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tick();
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        $display("txn reset released");
    endtask

    task automatic test_passthrough(input logic [3:0] op, input logic [31:0] alu,
                                    input logic [4:0] rd);
        in_valid = 1'b1; in_mem_op = op; in_alu_result = alu; in_rd = rd;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b want 1", out_valid); end
        checks++; if (out_data !== alu) begin errors++; $display("FAIL pass_data got %h want %h", out_data, alu); end
        checks++; if (out_rd !== rd) begin errors++; $display("FAIL pass_rd got %0d want %0d", out_rd, rd); end
        checks++; if (out_exc !== 1'b0) begin errors++; $display("FAIL pass_exc got %b want 0", out_exc); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pass_mem_req got %b want 0", mem_req); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drop got %b want 0", out_valid); end
        $display("txn pass op=%b alu=%h rd=%0d -> data=%h", op, alu, rd, alu);
    endtask

    // Load with gnt on the first REQ cycle and rvalid 2 cycles after gnt
    task automatic test_load(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        in_valid = 1'b1; in_mem_op = op; in_alu_result = addr; in_rd = rd;
        tick();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ld_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL ld_addr got %h want %h", mem_addr, exp_addr); end
        checks++; if (mem_wr !== 1'b0 || mem_wstrb !== 4'b0000) begin errors++; $display("FAIL ld_wr_strb got %b/%b want 0/0000", mem_wr, mem_wstrb); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_in_ready got %b want 0", in_ready); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ld_req_drop got %b want 0", mem_req); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_early_valid got %b want 0", out_valid); end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL ld_data got %h want %h", out_data, exp_data); end
        checks++; if (out_rd !== rd) begin errors++; $display("FAIL ld_rd got %0d want %0d", out_rd, rd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_drop got %b want 0", out_valid); end
        $display("txn load op=%b addr=%h rdata=%h -> data=%h", op, addr, rdata, exp_data);
    endtask

    // Store with gnt after gnt_dly extra REQ cycles
    task automatic test_store(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sd, input int gnt_dly,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_addr);
        in_valid = 1'b1; in_mem_op = op; in_alu_result = addr; in_store_data = sd; in_rd = 5'd11;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL st_req cyc%0d got %b want 1", i, mem_req); end
            checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL st_wr cyc%0d got %b want 1", i, mem_wr); end
            checks++; if (mem_wstrb !== exp_strb) begin errors++; $display("FAIL st_strb cyc%0d got %b want %b", i, mem_wstrb, exp_strb); end
            checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL st_wdata cyc%0d got %h want %h", i, mem_wdata, exp_wdata); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL st_addr cyc%0d got %h want %h", i, mem_addr, exp_addr); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_early_valid cyc%0d got %b want 0", i, out_valid); end
            if (i == gnt_dly) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop got %b want 0", mem_req); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL st_out got %h/%0d want 0/0", out_data, out_rd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_drop got %b want 0", out_valid); end
        $display("txn store op=%b addr=%h sd=%h -> strb=%b wdata=%h", op, addr, sd, exp_strb, exp_wdata);
    endtask

    task automatic test_misaligned(input logic [3:0] op, input logic [31:0] addr);
        in_valid = 1'b1; in_mem_op = op; in_alu_result = addr; in_rd = 5'd9;
        tick();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %b want 0", mem_req); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b want 1", out_valid); end
        checks++; if (out_exc !== 1'b1) begin errors++; $display("FAIL mis_exc got %b want 1", out_exc); end
        checks++; if (out_badaddr !== addr) begin errors++; $display("FAIL mis_badaddr got %h want %h", out_badaddr, addr); end
        checks++; if (out_rd !== 5'd0 || out_data !== 32'd0) begin errors++; $display("FAIL mis_out got %h/%0d want 0/0", out_data, out_rd); end
        tick();
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_after got %b/%b want 0/0", out_valid, mem_req); end
        $display("txn misaligned op=%b addr=%h -> exc", op, addr);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mem_op = 4'b0000; in_alu_result = 32'h0000_AAAA; in_rd = 5'd5;
        tick();
        // Queue the next op while the first one is stalled
        in_alu_result = 32'h0000_5555; in_rd = 5'd6;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b want 1", i, out_valid); end
            checks++; if (out_data !== 32'h0000_AAAA || out_rd !== 5'd5) begin errors++; $display("FAIL bp_hold cyc%0d got %h/%0d want 0000aaaa/5", i, out_data, out_rd); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h0000_5555 || out_rd !== 5'd6) begin errors++; $display("FAIL bp_b2b_data got %h/%0d want 00005555/6", out_data, out_rd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", out_valid); end
        $display("txn backpressure 5 cycles then back-to-back accept");
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; in_mem_op = 4'b1100; in_alu_result = 32'h0000_0100; in_rd = 5'd4;
        tick();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_addr got %h want 00000100", mem_addr); end
        resetn = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_wstrb !== 4'd0) begin errors++; $display("FAIL rw_mem_ctl got %b/%b/%b want 0", mem_req, mem_wr, mem_wstrb); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rw_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL rw_out got %b/%h/%0d want 0", out_valid, out_data, out_rd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rw_in_ready got %b want 0", in_ready); end
        tick();
        resetn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_stray_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rw_idle_ready got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin errors++; $display("FAIL rw_after got %b/%h want 0/0", out_valid, out_data); end
        $display("txn reset during WAIT, stray rvalid ignored");
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0;
        in_mem_op = '0; in_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; out_ready = 1'b1;

        test_reset();
        test_passthrough(4'b0000, 32'h0000_1234, 5'd7);
        test_passthrough(4'b0101, 32'h0000_CAFE, 5'd2);
        test_load(4'b1000, 32'h1000_0003, 32'h80FF_7F01, 5'd3, 32'h1000_0000, 32'hFFFF_FF80);
        test_load(4'b1001, 32'h1000_0003, 32'h80FF_7F01, 5'd3, 32'h1000_0000, 32'h0000_0080);
        test_load(4'b1010, 32'h0000_0042, 32'h8001_7FFF, 5'd8, 32'h0000_0040, 32'hFFFF_8001);
        test_load(4'b1011, 32'h0000_0042, 32'h8001_7FFF, 5'd8, 32'h0000_0040, 32'h0000_8001);
        test_load(4'b1100, 32'h0000_0044, 32'h8001_7FFF, 5'd1, 32'h0000_0044, 32'h8001_7FFF);
        test_store(4'b1110, 32'h2000_0002, 32'hDEAD_BEEF, 3, 4'b1100, 32'hBEEF_BEEF, 32'h2000_0000);
        test_store(4'b1101, 32'h2000_0011, 32'h1234_56A5, 0, 4'b0010, 32'hA5A5_A5A5, 32'h2000_0010);
        test_store(4'b1111, 32'h3000_0008, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D, 32'h3000_0008);
        test_misaligned(4'b1100, 32'h0000_0006);
        test_misaligned(4'b1110, 32'h0000_0011);
        test_backpressure();
        test_reset_mid_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
